// File: rtl/pu_riscv_ahb4_arb_pkg.sv
// Shared types for the PU AHB4 instruction/data arbiter.
package pu_riscv_ahb4_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic {
        INS = 1'b0,
        DAT = 1'b1
    } master_e;

    // Address-phase control bundle (address travels alongside, sized by PLEN)
    typedef struct packed {
        logic       hwrite;
        logic [2:0] hsize;
        logic [2:0] hburst;
        logic [3:0] hprot;
        logic       hmastlock;
        logic [1:0] htrans;
    } ahb_ctrl_t;

    // Beat types that continue a burst and therefore forbid a grant change
    function automatic logic is_burst_cont(input logic [1:0] htrans);
        return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
    endfunction

    // Beat types that open a data phase
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/pu_riscv_ahb4_arb_hold.sv
// One-entry holding register for an address phase the bus has not yet taken.
module pu_riscv_ahb4_arb_hold
    import pu_riscv_ahb4_arb_pkg::*;
#(
    parameter int unsigned PLEN = 32
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            i_capture,
    input  logic            i_release,
    input  logic [PLEN-1:0] i_addr,
    input  ahb_ctrl_t       i_ctrl,
    output logic            o_vld,
    output logic [PLEN-1:0] o_addr,
    output ahb_ctrl_t       o_ctrl
);

    logic            r_vld;
    logic [PLEN-1:0] r_addr;
    ahb_ctrl_t       r_ctrl;

    // Capture a parked address phase; drop it once the bus accepts the replay
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_vld  <= 1'b0;
            r_addr <= '0;
            r_ctrl <= '0;
        end else if (i_capture) begin
            r_vld  <= 1'b1;
            r_addr <= i_addr;
            r_ctrl <= i_ctrl;
        end else if (i_release) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_vld  = r_vld;
    assign o_addr = r_addr;
    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pu_riscv_ahb4_arbiter.sv
// Shares one AHB4 master port between the PU instruction and data masters.
// Arbitration happens only at transfer boundaries; bursts and locked
// sequences are never split. A master that loses the bus while issuing
// NONSEQ is parked in a holding register and replayed when granted.
// Optional: define PU_RISCV_AHB4_ARB_RR_EN for round-robin arbitration
// (default is fixed priority, data over instruction).
module pu_riscv_ahb4_arbiter
    import pu_riscv_ahb4_arb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PLEN = 32
) (
    input  logic            HCLK,
    input  logic            HRESETn,

    input  logic            ins_HSEL,
    input  logic [PLEN-1:0] ins_HADDR,
    input  logic [XLEN-1:0] ins_HWDATA,
    output logic [XLEN-1:0] ins_HRDATA,
    input  logic            ins_HWRITE,
    input  logic [2:0]      ins_HSIZE,
    input  logic [2:0]      ins_HBURST,
    input  logic [3:0]      ins_HPROT,
    input  logic [1:0]      ins_HTRANS,
    input  logic            ins_HMASTLOCK,
    output logic            ins_HREADY,
    output logic            ins_HRESP,

    input  logic            dat_HSEL,
    input  logic [PLEN-1:0] dat_HADDR,
    input  logic [XLEN-1:0] dat_HWDATA,
    output logic [XLEN-1:0] dat_HRDATA,
    input  logic            dat_HWRITE,
    input  logic [2:0]      dat_HSIZE,
    input  logic [2:0]      dat_HBURST,
    input  logic [3:0]      dat_HPROT,
    input  logic [1:0]      dat_HTRANS,
    input  logic            dat_HMASTLOCK,
    output logic            dat_HREADY,
    output logic            dat_HRESP,

    output logic            mst_HSEL,
    output logic [PLEN-1:0] mst_HADDR,
    output logic [XLEN-1:0] mst_HWDATA,
    input  logic [XLEN-1:0] mst_HRDATA,
    output logic            mst_HWRITE,
    output logic [2:0]      mst_HSIZE,
    output logic [2:0]      mst_HBURST,
    output logic [3:0]      mst_HPROT,
    output logic [1:0]      mst_HTRANS,
    output logic            mst_HMASTLOCK,
    input  logic            mst_HREADY,
    input  logic            mst_HRESP
);

    master_e         r_gnt;
    logic            r_dph_valid;
    master_e         r_dph_owner;

    master_e         w_gnt;
    ahb_ctrl_t       w_ins_live, w_dat_live;
    ahb_ctrl_t       w_ins_eff, w_dat_eff, w_own_eff, w_bus_ctrl;
    logic [PLEN-1:0] w_ins_eff_addr, w_dat_eff_addr, w_bus_addr;
    logic            w_ins_eff_sel, w_dat_eff_sel, w_bus_sel;
    logic            w_ins_nonseq, w_dat_nonseq;
    logic            w_req_ins, w_req_dat, w_own_keep;
    logic            w_ins_hready, w_dat_hready;
    logic            w_cap_ins, w_cap_dat, w_rel_ins, w_rel_dat;
    logic            w_hold_vld_ins, w_hold_vld_dat;
    logic [PLEN-1:0] w_hold_addr_ins, w_hold_addr_dat;
    ahb_ctrl_t       w_hold_ctrl_ins, w_hold_ctrl_dat;

    // Pack live master controls and pick held or live view per master
    always_comb begin
        w_ins_live.hwrite    = ins_HWRITE;
        w_ins_live.hsize     = ins_HSIZE;
        w_ins_live.hburst    = ins_HBURST;
        w_ins_live.hprot     = ins_HPROT;
        w_ins_live.hmastlock = ins_HMASTLOCK;
        w_ins_live.htrans    = ins_HTRANS;
        w_dat_live.hwrite    = dat_HWRITE;
        w_dat_live.hsize     = dat_HSIZE;
        w_dat_live.hburst    = dat_HBURST;
        w_dat_live.hprot     = dat_HPROT;
        w_dat_live.hmastlock = dat_HMASTLOCK;
        w_dat_live.htrans    = dat_HTRANS;

        w_ins_eff      = w_hold_vld_ins ? w_hold_ctrl_ins : w_ins_live;
        w_ins_eff_addr = w_hold_vld_ins ? w_hold_addr_ins : ins_HADDR;
        w_ins_eff_sel  = w_hold_vld_ins | ins_HSEL;
        w_dat_eff      = w_hold_vld_dat ? w_hold_ctrl_dat : w_dat_live;
        w_dat_eff_addr = w_hold_vld_dat ? w_hold_addr_dat : dat_HADDR;
        w_dat_eff_sel  = w_hold_vld_dat | dat_HSEL;
    end

    assign w_ins_nonseq = ins_HSEL & (ins_HTRANS == HTRANS_NONSEQ);
    assign w_dat_nonseq = dat_HSEL & (dat_HTRANS == HTRANS_NONSEQ);
    assign w_req_ins    = w_hold_vld_ins | w_ins_nonseq;
    assign w_req_dat    = w_hold_vld_dat | w_dat_nonseq;

    // Grant selection: hold during wait states, bursts and locks; else arbitrate
    always_comb begin
        w_gnt      = r_gnt;
        w_own_eff  = (r_gnt == DAT) ? w_dat_eff : w_ins_eff;
        w_own_keep = w_own_eff.hmastlock | is_burst_cont(w_own_eff.htrans);
        if (mst_HREADY && !w_own_keep) begin
            if (w_req_dat && w_req_ins) begin
`ifdef PU_RISCV_AHB4_ARB_RR_EN
                w_gnt = (r_gnt == DAT) ? INS : DAT;
`else
                w_gnt = DAT;
`endif
            end else if (w_req_dat) begin
                w_gnt = DAT;
            end else if (w_req_ins) begin
                w_gnt = INS;
            end
        end
    end

    // Address/control mux toward the shared bus
    always_comb begin
        w_bus_ctrl = (w_gnt == DAT) ? w_dat_eff      : w_ins_eff;
        w_bus_addr = (w_gnt == DAT) ? w_dat_eff_addr : w_ins_eff_addr;
        w_bus_sel  = (w_gnt == DAT) ? w_dat_eff_sel  : w_ins_eff_sel;
    end

    // Masters see the bus HREADY in their own data phase, stall while parked
    always_comb begin
        w_ins_hready = (r_dph_valid && (r_dph_owner == INS)) ? mst_HREADY : !w_hold_vld_ins;
        w_dat_hready = (r_dph_valid && (r_dph_owner == DAT)) ? mst_HREADY : !w_hold_vld_dat;
    end

    // Park any NONSEQ the master believes accepted but the bus did not sample
    always_comb begin
        w_rel_ins = (w_gnt == INS) & mst_HREADY;
        w_rel_dat = (w_gnt == DAT) & mst_HREADY;
        w_cap_ins = w_ins_nonseq & w_ins_hready & !w_rel_ins;
        w_cap_dat = w_dat_nonseq & w_dat_hready & !w_rel_dat;
    end

    pu_riscv_ahb4_arb_hold #(.PLEN(PLEN)) u_hold_ins (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .i_capture (w_cap_ins),
        .i_release (w_rel_ins),
        .i_addr    (ins_HADDR),
        .i_ctrl    (w_ins_live),
        .o_vld     (w_hold_vld_ins),
        .o_addr    (w_hold_addr_ins),
        .o_ctrl    (w_hold_ctrl_ins)
    );

    pu_riscv_ahb4_arb_hold #(.PLEN(PLEN)) u_hold_dat (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .i_capture (w_cap_dat),
        .i_release (w_rel_dat),
        .i_addr    (dat_HADDR),
        .i_ctrl    (w_dat_live),
        .o_vld     (w_hold_vld_dat),
        .o_addr    (w_hold_addr_dat),
        .o_ctrl    (w_hold_ctrl_dat)
    );

    // Grant and data-phase ownership advance only when the bus is ready
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_gnt       <= INS;
            r_dph_valid <= 1'b0;
            r_dph_owner <= INS;
        end else if (mst_HREADY) begin
            r_gnt       <= w_gnt;
            r_dph_valid <= is_active(mst_HTRANS);
            r_dph_owner <= w_gnt;
        end
    end

    // Bus outputs; controls forced idle while reset is asserted
    assign mst_HSEL      = HRESETn & w_bus_sel;
    assign mst_HADDR     = w_bus_addr;
    assign mst_HWRITE    = w_bus_ctrl.hwrite;
    assign mst_HSIZE     = w_bus_ctrl.hsize;
    assign mst_HBURST    = w_bus_ctrl.hburst;
    assign mst_HPROT     = w_bus_ctrl.hprot;
    assign mst_HTRANS    = HRESETn ? w_bus_ctrl.htrans : HTRANS_IDLE;
    assign mst_HMASTLOCK = HRESETn & w_bus_ctrl.hmastlock;
    assign mst_HWDATA    = (r_dph_owner == DAT) ? dat_HWDATA : ins_HWDATA;

    // Response path: read data broadcast, ready/response steered to data owner
    assign ins_HRDATA = mst_HRDATA;
    assign dat_HRDATA = mst_HRDATA;
    assign ins_HREADY = w_ins_hready;
    assign dat_HREADY = w_dat_hready;
    assign ins_HRESP  = r_dph_valid & (r_dph_owner == INS) & mst_HRESP;
    assign dat_HRESP  = r_dph_valid & (r_dph_owner == DAT) & mst_HRESP;

endmodule

// File: doc/pu_riscv_ahb4_arbiter.md
Name:
pu_riscv_ahb4_arbiter

Overview:
- Shares one AHB4 (AHB-Lite) master port between the PU instruction and data AHB4 interfaces, so a single-ported system bus can host one core.
- Sits between the PU core's ins_*/dat_* ports and the interconnect.
- Arbitrates only at transfer boundaries and never splits bursts or locked sequences.
- Holds a losing master's accepted address in a one-entry holding register and replays it when that master is granted.

Parameters:
- XLEN, 32, data width.
- PLEN, 32, physical address width.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- ins_HSEL, ins_HWRITE, ins_HMASTLOCK  in  1 each  instruction master controls.
- ins_HADDR  in  PLEN  instruction master address.
- ins_HWDATA  in  XLEN  instruction master write data.
- ins_HSIZE, ins_HBURST  in  3 each  instruction master size and burst.
- ins_HPROT  in  4  instruction master protection.
- ins_HTRANS  in  2  instruction master transfer type.
- ins_HRDATA  out  XLEN  read data to instruction master.
- ins_HREADY, ins_HRESP  out  1 each  ready and response to instruction master.
- dat_*  same set, directions and widths as ins_*  data master.
- mst_HSEL, mst_HWRITE, mst_HMASTLOCK  out  1 each  shared bus controls.
- mst_HADDR  out  PLEN  shared bus address.
- mst_HWDATA  out  XLEN  shared bus write data.
- mst_HSIZE, mst_HBURST  out  3 each  shared bus size and burst.
- mst_HPROT  out  4  shared bus protection.
- mst_HTRANS  out  2  shared bus transfer type.
- mst_HRDATA  in  XLEN  shared bus read data.
- mst_HREADY, mst_HRESP  in  1 each  shared bus ready and response.

Behaviour:
- Clock/reset: single clock HCLK; HRESETn asynchronous, active-low.
- Reset state: gnt_q=INS (park); dph_valid=0; hold_vld_ins=hold_vld_dat=0.
  - mst_HTRANS=IDLE, mst_HSEL=0, mst_HMASTLOCK=0.
  - ins_HREADY=dat_HREADY=1; ins_HRESP=dat_HRESP=0.
- Request: req_x = hold_vld_x | (x_HSEL & x_HTRANS==NONSEQ).
- Grant (combinational gnt):
  - If mst_HREADY=0, gnt=gnt_q.
  - Else if the owner's current beat is SEQ/BUSY, or owner HMASTLOCK=1, gnt=gnt_q (no preemption).
  - Else highest-priority requester wins; dat beats ins (fixed priority).
  - No request: park, gnt=gnt_q.
  - gnt_q <= gnt on each edge with mst_HREADY=1.
- Address mux: mst address/control = hold_x if hold_vld_x, else live x_* signals, where x=gnt.
- Holding register: master x presents NONSEQ with x_HREADY=1 while gnt!=x -> capture HADDR/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HTRANS into hold_x and set hold_vld_x.
  - hold_vld_x clears on the edge where gnt==x and mst_HREADY=1, i.e. the held address is accepted by the bus.
- Data phase tracking: on mst_HREADY=1, dph_valid <= (mst_HTRANS is NONSEQ/SEQ) and dph_owner <= gnt.
  - mst_HWDATA = dph_owner's HWDATA.
  - mst_HRDATA is broadcast to both masters.
  - HRESP goes to dph_owner only; the other master gets 0.
- Per-master x_HREADY:
  - dph_valid & dph_owner==x -> mst_HREADY.
  - Otherwise hold_vld_x -> 0; the held transfer's data phase is stalled and the master keeps HWDATA stable.
  - Otherwise -> 1.
- Latency:
  - Granted master with no hold: zero added cycles.
  - Preempted master: replay starts the cycle the owner reaches a boundary.
- ERROR response: 2-cycle HRESP passes through to dph_owner. The arbiter does not cancel the other master's hold.
- Simultaneous NONSEQ from both masters while idle: dat is granted; the ins address is captured into hold_ins in the same cycle.
- Reset mid-transfer: all state is cleared immediately and holds are discarded; masters restart.

Optional Feature:
- Macro: PU_RISCV_AHB4_ARB_RR_EN.
- Defined: round-robin arbitration; the master granted last has the lower priority at the next boundary where both request.
- Undefined: fixed priority, dat over ins.
- Burst and lock protection are unchanged in both modes.

Decomposition:
- Package pu_riscv_ahb4_arb_pkg:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - Master enum {INS=0, DAT=1}.
  - Packed struct for the address/control bundle.
- Sub-module pu_riscv_ahb4_arb_hold: one-entry capture register plus valid bit, instantiated once per master.

Test Plan:
- Single ins NONSEQ read at 0x8000_0000, dat idle -> appears on mst bus the same cycle; ins_HREADY follows mst_HREADY; ins_HRDATA=mst_HRDATA.
- Both masters NONSEQ in the same cycle (ins 0x100, dat 0x200) -> mst_HADDR=0x200 first, 0x100 the next cycle from the hold; ins_HREADY=0 until its data phase; dat_HRESP isolated from ins.
- Ins INCR4 burst in progress, dat requests at beat 2 -> all four ins beats complete contiguously; dat granted at the following boundary.
- Dat locked read-modify-write (HMASTLOCK=1) with ins requesting -> ins withheld until HMASTLOCK drops; mst_HMASTLOCK continuous.
- Dat write 0xDEADBEEF preempting ins with a 2-wait-state slave -> mst_HWDATA=0xDEADBEEF during the dat data phase; the held ins transfer then replays with its original address.
- With PU_RISCV_AHB4_ARB_RR_EN, both masters issue back-to-back singles -> grants alternate DAT, INS, DAT, INS; without the macro, dat wins every contested boundary.
